// File: rtl/song_sequencer.sv
// Song sequencer: steps through an external (note, duration) ROM and drives the
// tone generator for millisecond-accurate durations, each followed by a silent gap.
module song_sequencer #(
  parameter int SONG_LEN = 16,
  parameter int UNIT_MS  = 50,
  parameter int GAP_MS   = 20,
  parameter int TPM_W    = 16,
  localparam int AW = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TPM_W-1:0] ticks_per_milli,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  output logic [AW-1:0]    rom_addr,
  input  logic [3:0]       rom_note,
  input  logic [3:0]       rom_dur,
  output logic [3:0]       note_out,
  output logic             tone_en,
  output logic [7:0]       led,
  output logic             busy,
  output logic             done
);
  localparam int MS_MAX = (15 * UNIT_MS > GAP_MS) ? 15 * UNIT_MS : GAP_MS;
  localparam int MSW    = $clog2(MS_MAX + 1);
  localparam logic [AW-1:0] LAST = AW'(SONG_LEN - 1);

  typedef enum logic [2:0] {IDLE, FETCH, PLAY, GAP, FINISH} state_t;
  state_t state, state_nxt;

  logic [TPM_W-1:0] tpm_eff, presc, presc_nxt;
  logic [MSW-1:0]   ms_rem, ms_rem_nxt;
  logic [AW-1:0]    addr_nxt;
  logic [3:0]       note_nxt;
  logic             tone_nxt, done_nxt, ms_tick, last_ms;

  assign tpm_eff = (ticks_per_milli == '0) ? TPM_W'(1) : ticks_per_milli;
  // >= rather than == so a shrinking ticks_per_milli cannot strand the count
  assign ms_tick = (presc >= tpm_eff - TPM_W'(1));
  assign last_ms = ms_tick && (ms_rem == MSW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      note_out <= '0;
      tone_en  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      led      <= '0;
      presc    <= '0;
      ms_rem   <= '0;
    end else begin
      state    <= state_nxt;
      rom_addr <= addr_nxt;
      note_out <= note_nxt;
      tone_en  <= tone_nxt;
      done     <= done_nxt;
      busy     <= (state_nxt != IDLE);
      led      <= {(state_nxt != IDLE), tone_nxt, 2'b00, note_nxt};
      presc    <= presc_nxt;
      ms_rem   <= ms_rem_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (stop) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (start) state_nxt = FETCH;
        FETCH: begin
          if (rom_dur != 4'd0)                  state_nxt = PLAY;
          else if (loop_en && rom_addr != '0)   state_nxt = FETCH;
          else                                  state_nxt = FINISH;
        end
        PLAY:    if (last_ms) state_nxt = GAP;
        GAP:     if (last_ms) state_nxt = (rom_addr == LAST && !loop_en) ? FINISH : FETCH;
        FINISH:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    addr_nxt   = rom_addr;
    note_nxt   = note_out;
    tone_nxt   = tone_en;
    done_nxt   = 1'b0;
    presc_nxt  = '0;
    ms_rem_nxt = ms_rem;
    if (state == PLAY || state == GAP) begin
      presc_nxt = ms_tick ? '0 : presc + TPM_W'(1);
      if (ms_tick) ms_rem_nxt = ms_rem - MSW'(1);
    end
    if (stop) begin
      addr_nxt = '0;
      note_nxt = '0;
      tone_nxt = 1'b0;
    end else begin
      case (state)
        IDLE:  if (state_nxt == FETCH) addr_nxt = '0;
        FETCH: begin
          if (state_nxt == PLAY) begin
            note_nxt   = rom_note;
            tone_nxt   = (rom_note != 4'd0);
            ms_rem_nxt = MSW'(rom_dur) * MSW'(UNIT_MS);
          end else if (state_nxt == FETCH) addr_nxt = '0;
        end
        PLAY: if (state_nxt == GAP) begin
          tone_nxt   = 1'b0;
          ms_rem_nxt = MSW'(GAP_MS);
        end
        GAP: if (state_nxt == FETCH) addr_nxt = (rom_addr == LAST) ? '0 : rom_addr + AW'(1);
        default: ;
      endcase
      if (state_nxt == FINISH) begin
        note_nxt = '0;
        tone_nxt = 1'b0;
        done_nxt = 1'b1;
      end
    end
    // each PLAY/GAP phase starts from a clean prescaler
    if (state_nxt != state || (state_nxt != PLAY && state_nxt != GAP)) presc_nxt = '0;
  end
endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: vector table, directed corner sequences and
// randomized songs checked against a per-cycle expected trace built from the song.
module tb_song_sequencer;
  localparam int SL = 16, U = 1, G = 2, TW = 16, AW = 4;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [TW-1:0] ticks_per_milli = 16'd3;
  logic [AW-1:0] rom_addr;
  logic [3:0]    rom_note, rom_dur, note_out;
  logic          tone_en, busy, done;
  logic [7:0]    led;
  logic [3:0]    rom_n [SL];
  logic [3:0]    rom_d [SL];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  assign rom_note = rom_n[rom_addr];
  assign rom_dur  = rom_d[rom_addr];

  song_sequencer #(.SONG_LEN(SL), .UNIT_MS(U), .GAP_MS(G), .TPM_W(TW)) dut (
    .clk(clk), .rst(rst), .ticks_per_milli(ticks_per_milli), .start(start), .stop(stop),
    .loop_en(loop_en), .rom_addr(rom_addr), .rom_note(rom_note), .rom_dur(rom_dur),
    .note_out(note_out), .tone_en(tone_en), .led(led), .busy(busy), .done(done));

  typedef struct { int addr; int note; int tone; int busy; int done; } obs_t;
  typedef struct { bit start; bit stop; int n; obs_t e; } vec_t;
  obs_t exp_q[$];
  vec_t tbl[12];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_obs(input string tag, input obs_t e);
    chk({tag, "_tone"}, int'(tone_en), e.tone);
    chk({tag, "_note"}, int'(note_out), e.note);
    chk({tag, "_busy"}, int'(busy), e.busy);
    chk({tag, "_done"}, int'(done), e.done);
    chk({tag, "_led"}, int'(led), (e.busy << 7) | (e.tone << 6) | e.note);
    if (e.addr >= 0) chk({tag, "_addr"}, int'(rom_addr), e.addr);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load_basic();
    for (int i = 0; i < SL; i++) begin rom_n[i] = 4'd0; rom_d[i] = 4'd0; end
    rom_n[0] = 4'd5; rom_d[0] = 4'd2;
    rom_n[1] = 4'd0; rom_d[1] = 4'd1;
    rom_n[2] = 4'd9; rom_d[2] = 4'd1;
    rom_n[3] = 4'd3; rom_d[3] = 4'd0;
  endtask

  // Expected trace from the cycle after start: one fetch cycle per entry, then
  // dur*U*tpm tone cycles and G*tpm gap cycles; FINISH then IDLE end the song.
  task automatic build(input int tpm, input bit lp, input int maxc);
    int a = 0, note = 0;
    bit fin = 0, fetch = 1;
    exp_q.delete();
    while (!fin && exp_q.size() < maxc) begin
      if (fetch) exp_q.push_back('{a, note, 0, 1, 0});
      fetch = 1;
      if (rom_d[a] == 0) begin
        if (lp && a != 0) a = 0;
        else fin = 1;
      end else begin
        note = int'(rom_n[a]);
        repeat (int'(rom_d[a]) * U * tpm) exp_q.push_back('{a, note, int'(note != 0), 1, 0});
        repeat (G * tpm) exp_q.push_back('{a, note, 0, 1, 0});
        if (a == SL - 1) begin
          if (lp) a = 0;
          else fin = 1;
        end else a++;
      end
    end
    if (fin) begin
      exp_q.push_back('{-1, 0, 0, 1, 1});
      exp_q.push_back('{-1, 0, 0, 0, 0});
    end
  endtask

  task automatic run_model(input string tag, input int tpm_in, input bit lp, input int maxc);
    int te;
    te = (tpm_in == 0) ? 1 : tpm_in;
    ticks_per_milli = TW'(tpm_in);
    loop_en = lp;
    build(te, lp, maxc);
    start = 1'b1; step(); start = 1'b0;
    foreach (exp_q[i]) begin
      if (i > 0) step();
      check_obs(tag, exp_q[i]);
    end
    if (exp_q[exp_q.size() - 1].busy != 0) begin
      stop = 1'b1; step(); stop = 1'b0;
      check_obs({tag, "_stop"}, '{0, 0, 0, 0, 0});
    end
    loop_en = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int nd, cyc, lowc;
    bit found;
    tbl[0]  = '{1, 0, 1, '{0, 0, 0, 1, 0}};
    tbl[1]  = '{0, 0, 6, '{0, 5, 1, 1, 0}};
    tbl[2]  = '{0, 0, 6, '{0, 5, 0, 1, 0}};
    tbl[3]  = '{0, 0, 1, '{1, 5, 0, 1, 0}};
    tbl[4]  = '{0, 0, 3, '{1, 0, 0, 1, 0}};
    tbl[5]  = '{0, 0, 6, '{1, 0, 0, 1, 0}};
    tbl[6]  = '{0, 0, 1, '{2, 0, 0, 1, 0}};
    tbl[7]  = '{0, 0, 3, '{2, 9, 1, 1, 0}};
    tbl[8]  = '{0, 0, 6, '{2, 9, 0, 1, 0}};
    tbl[9]  = '{0, 0, 1, '{3, 9, 0, 1, 0}};
    tbl[10] = '{0, 0, 1, '{-1, 0, 0, 1, 1}};
    tbl[11] = '{0, 0, 3, '{-1, 0, 0, 0, 0}};

    load_basic();
    step(); step();
    check_obs("reset", '{0, 0, 0, 0, 0});
    rst = 1'b0;
    step();
    check_obs("idle", '{0, 0, 0, 0, 0});

    // basic play, run-length vectors
    ticks_per_milli = 16'd3;
    foreach (tbl[r]) begin
      start = tbl[r].start; stop = tbl[r].stop;
      for (int k = 0; k < tbl[r].n; k++) begin
        step();
        start = 1'b0; stop = 1'b0;
        check_obs($sformatf("basic_row%0d", r), tbl[r].e);
      end
    end

    run_model("basic_model", 3, 0, 1000);
    run_model("loop_model", 3, 1, 90);

    // loop, then drop loop_en mid-song: exactly one done
    load_basic(); ticks_per_milli = 16'd3; loop_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    nd = 0;
    repeat (60) begin step(); if (done) nd++; end
    chk("loop_no_done", nd, 0);
    chk("loop_busy", int'(busy), 1);
    loop_en = 1'b0; cyc = 0;
    while (busy && cyc < 200) begin step(); cyc++; if (done) nd++; end
    chk("loop_drop_idle", int'(busy), 0);
    chk("loop_drop_done", nd, 1);

    // stop, then reset, two cycles into note 9
    for (int v = 0; v < 2; v++) begin
      load_basic(); ticks_per_milli = 16'd3;
      start = 1'b1; step(); start = 1'b0;
      nd = 0; cyc = 0; found = 0;
      while (!found && cyc < 100) begin
        step(); cyc++;
        if (done) nd++;
        if (tone_en && note_out == 4'd9) found = 1;
      end
      chk(v ? "rst_find9" : "stop_find9", int'(found), 1);
      step();
      if (v) rst = 1'b1; else stop = 1'b1;
      step();
      check_obs(v ? "rst_abort" : "stop_abort", '{0, 0, 0, 0, 0});
      repeat (3) begin step(); if (done) nd++; end
      rst = 1'b0; stop = 1'b0;
      chk(v ? "rst_no_done" : "stop_no_done", nd, 0);
      step();
      chk(v ? "rst_stay_idle" : "stop_stay_idle", int'(busy), 0);
    end

    // end marker at entry 0 with loop_en must still finish
    for (int i = 0; i < SL; i++) begin rom_n[i] = 4'd7; rom_d[i] = 4'd0; end
    run_model("marker0_loop", 2, 1, 100);

    // all entries non-zero: end-of-song at the last address
    for (int i = 0; i < SL; i++) begin
      rom_n[i] = 4'($urandom_range(0, 15));
      rom_d[i] = 4'($urandom_range(1, 2));
    end
    run_model("full16", 1, 0, 2000);
    run_model("full16_loop", 1, 1, 150);

    load_basic();
    run_model("tpm0", 0, 0, 1000);

    // start held through the song: restart only after FINISH
    load_basic(); ticks_per_milli = 16'd1;
    start = 1'b1; step();
    cyc = 0; found = 0; lowc = 0;
    while (!found && cyc < 100) begin
      step(); cyc++;
      if (!busy) lowc++;
      if (done) found = 1;
    end
    chk("held_done", int'(found), 1);
    chk("held_no_restart", lowc, 0);
    step();
    chk("held_idle", int'(busy), 0);
    step();
    chk("held_restart_busy", int'(busy), 1);
    chk("held_restart_addr", int'(rom_addr), 0);
    start = 1'b0; stop = 1'b1; step(); stop = 1'b0;
    chk("held_stop", int'(busy), 0);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    for (int k = 0; k < 3; k++) begin step(); chk("startstop_idle", int'(busy), 0); end
    start = 1'b0; stop = 1'b0;

    // randomized songs
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < SL; i++) begin
        rom_n[i] = 4'($urandom_range(0, 15));
        rom_d[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
      end
      run_model($sformatf("rand%0d", t), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 300);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
Sequences the speaker/LED music datapath by stepping through an external song ROM of (note, duration) entries.
- Per entry, drives note_out/tone_en to the tone generator for a millisecond-accurate duration, then a fixed silent gap.
- Millisecond timing is derived from the ticks_per_milli input, the same scheme the top level uses.
- Sits between the top-level controls (start/stop/loop) and the tone generator / LED segment driver.

Parameters:
SONG_LEN, 16, number of ROM entries; rom_addr width AW = clog2(SONG_LEN)
UNIT_MS, 50, milliseconds per duration unit
GAP_MS, 20, silent gap after every entry, in ms
TPM_W, 16, width of ticks_per_milli

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ticks_per_milli  in  TPM_W  clk cycles per ms; value 0 treated as 1
start  in  1  level; sampled only in IDLE
stop  in  1  level; abort from any state, priority over start
loop_en  in  1  replay from entry 0 at end of song
rom_addr  out  AW  registered ROM address
rom_note  in  4  combinational ROM data, 0 = rest
rom_dur  in  4  combinational ROM data, units of UNIT_MS; 0 = end-of-song marker
note_out  out  4  current note index to tone generator
tone_en  out  1  tone generator enable
led  out  8  {busy, tone_en, 2'b00, note_out}
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse on natural song completion

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, rom_addr=0, note_out=0, tone_en=0, done=0, busy=0, led=0, prescaler and ms counter=0. A reset asserted mid-song aborts immediately with the same values.
- All outputs are registered. tpm_eff = max(ticks_per_milli, 1), sampled continuously.
- Prescaler: counts 0..tpm_eff-1 and pulses ms_tick on the count tpm_eff-1. It is cleared on every entry to PLAY or GAP, so each phase lasts an exact multiple of tpm_eff cycles.
- States: IDLE, FETCH, PLAY, GAP, FINISH.
- IDLE:
  - start=1 and stop=0 -> FETCH, with rom_addr=0.
  - Otherwise stay; tone_en=0, note_out holds 0.
- FETCH (1 cycle): ROM is read at rom_addr.
  - rom_dur!=0 -> PLAY. Latch note_out=rom_note, ms_remaining=rom_dur*UNIT_MS (width sized for 15*UNIT_MS), tone_en=(rom_note!=0).
  - rom_dur==0 and loop_en=1 and rom_addr!=0 -> FETCH with rom_addr=0.
  - rom_dur==0 otherwise -> FINISH. A marker at entry 0 never loops.
- PLAY:
  - Decrement ms_remaining on each ms_tick.
  - On the ms_tick that takes it to 0 -> GAP. In that transition, tone_en=0 and note_out holds.
  - PLAY lasts exactly rom_dur*UNIT_MS*tpm_eff cycles.
- GAP:
  - Lasts exactly GAP_MS*tpm_eff cycles, tone_en=0.
  - At the end: if rom_addr==SONG_LEN-1, apply the end-of-song rule (loop_en -> FETCH at addr 0, else FINISH).
  - Otherwise rom_addr+1 -> FETCH.
- FINISH (1 cycle): done=1, note_out cleared to 0 -> IDLE. busy is still 1 during FINISH and drops on the IDLE cycle.
- stop=1 in any non-IDLE state: next state IDLE; tone_en=0, note_out=0, rom_addr=0, no done pulse. If stop and start are both 1 in IDLE, stay in IDLE.
- start while busy is ignored; there is no restart mid-song.
- loop_en is sampled only at the end-of-song decision.
- Latency: start sampled at edge N -> FETCH during cycle N+1 -> tone_en/note_out valid from cycle N+2.

Test Plan:
- Basic play. UNIT_MS=1, GAP_MS=2, tpm=3; ROM {(5,2),(0,1),(9,1),(x,0)}; start pulse -> tone_en=1 with note_out=5 for 6 cycles, gap 6 cycles, tone_en=0 with note_out=0 for 3 cycles (rest), gap, note 9 for 3 cycles, gap, done pulses once, busy falls, led=0x00.
- Loop. Same ROM, loop_en=1 -> after the third entry's gap, rom_addr returns to 0, note 5 replays, no done pulse. Drop loop_en mid-song -> finishes with exactly one done.
- Stop / reset abort. stop asserted 2 cycles into note 9 -> next cycle IDLE, tone_en=0, busy=0, done never pulses. Repeat with rst instead: all outputs 0 next cycle.
- Boundaries.
  - ROM entry 0 = (x,0) with loop_en=1 -> FETCH, FINISH, done, IDLE (no hang).
  - All 16 entries non-zero -> after entry 15's gap, end-of-song handling with no address overflow.
  - ticks_per_milli=0 -> behaves as tpm=1 (dur*UNIT_MS cycles per note).
- Start gating. start held high throughout the song -> no restart until IDLE is reached; restarts one cycle after FINISH. start and stop both high in IDLE -> stays IDLE.
